// File: rtl/axi_w_order_ctrl_m3_if.sv
// Slave-port AW/W handshake bundle for the write-order scheduler, plus its status outputs.
interface axi_w_order_ctrl_m3_if #(
  parameter int unsigned NUM_MASTER = 3,
  parameter int unsigned W_PTR      = 2
);
  logic [NUM_MASTER-1:0] AWGRANT;
  logic                  S_AWVALID;
  logic                  S_AWREADY;
  logic [7:0]            S_AWLEN;
  logic                  S_WVALID;
  logic                  S_WREADY;
  logic                  S_WLAST;
  logic [NUM_MASTER-1:0] w_order_grant;
  logic                  aw_stall;
  logic [W_PTR:0]        occupancy;
  logic                  err_wlast;
  logic                  err_ovf;

  modport master (
    output AWGRANT, S_AWVALID, S_AWREADY, S_AWLEN, S_WVALID, S_WREADY, S_WLAST,
    input  w_order_grant, aw_stall, occupancy, err_wlast, err_ovf
  );

  modport slave (
    input  AWGRANT, S_AWVALID, S_AWREADY, S_AWLEN, S_WVALID, S_WREADY, S_WLAST,
    output w_order_grant, aw_stall, occupancy, err_wlast, err_ovf
  );
endinterface

// File: rtl/axi_w_order_ctrl_m3.sv
// Write-order scheduler: queues AW winners in acceptance order and grants the W channel
// to the head master, checking WLAST placement against the recorded AWLEN.
module axi_w_order_ctrl_m3 #(
  parameter int unsigned NUM_MASTER = 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned W_PTR      = 2
) (
  input logic                  AXI_CLK,
  input logic                  AXI_RST,
  axi_w_order_ctrl_m3_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  localparam logic [W_PTR:0]   FullCnt = (W_PTR+1)'(DEPTH);
  localparam logic [W_PTR:0]   OccOne  = (W_PTR+1)'(1);
  localparam logic [W_PTR-1:0] PtrOne  = W_PTR'(1);

  state_e                state_q, state_d;
  logic [NUM_MASTER-1:0] grant_mem [DEPTH];
  logic [7:0]            len_mem   [DEPTH];
  logic [W_PTR-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [W_PTR:0]        occ_q, occ_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d, cur_len_q, cur_len_d, next_head_len;
  logic                  err_wlast_q, err_wlast_d, err_ovf_q, err_ovf_d;
  logic                  aw_hs, grant_ok, full, push, w_beat, w_end;
  logic [NUM_MASTER-1:0] order_grant;

  always_comb begin
    aw_hs    = bus.S_AWVALID & bus.S_AWREADY;
    grant_ok = $onehot(bus.AWGRANT);
    full     = (occ_q == FullCnt);
    push     = aw_hs & grant_ok & ~full;
    w_beat   = bus.S_WVALID & bus.S_WREADY & (state_q == StBurst);
    w_end    = w_beat & bus.S_WLAST;

    wr_ptr_d  = push  ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d  = w_end ? rd_ptr_q + PtrOne : rd_ptr_q;
    err_ovf_d = err_ovf_q | (aw_hs & (~grant_ok | full));

    case ({push, w_end})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase

    // With one entry left, the next head is the entry being pushed this very cycle.
    rd_ptr_nxt    = rd_ptr_q + PtrOne;
    next_head_len = (push && occ_q == OccOne) ? bus.S_AWLEN : len_mem[rd_ptr_nxt];
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    cur_len_d   = cur_len_q;
    err_wlast_d = err_wlast_q;
    order_grant = '0;
    unique case (state_q)
      StIdle: begin
        if (occ_q != '0) begin
          state_d    = StBurst;
          beat_cnt_d = 8'd0;
          cur_len_d  = len_mem[rd_ptr_q];
        end
      end
      StBurst: begin
        order_grant = grant_mem[rd_ptr_q];
        if (w_beat) begin
          // Flags both an early WLAST and a missing WLAST on the final beat.
          if (bus.S_WLAST != (beat_cnt_q == cur_len_q)) err_wlast_d = 1'b1;
          if (beat_cnt_q != 8'hff) beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if (w_end) begin
          if (occ_d != '0) begin
            beat_cnt_d = 8'd0;
            cur_len_d  = next_head_len;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AXI_CLK) begin
    if (AXI_RST) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      beat_cnt_q  <= '0;
      cur_len_q   <= '0;
      err_wlast_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      beat_cnt_q  <= beat_cnt_d;
      cur_len_q   <= cur_len_d;
      err_wlast_q <= err_wlast_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in occ_q.
  always_ff @(posedge AXI_CLK) begin
    if (push) begin
      grant_mem[wr_ptr_q] <= bus.AWGRANT;
      len_mem[wr_ptr_q]   <= bus.S_AWLEN;
    end
  end

  assign bus.w_order_grant = order_grant;
  assign bus.aw_stall      = full;
  assign bus.occupancy     = occ_q;
  assign bus.err_wlast     = err_wlast_q;
  assign bus.err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_axi_w_order_ctrl_m3.sv
// Bench for axi_w_order_ctrl_m3: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based reference model.
module tb_axi_w_order_ctrl_m3;
  localparam int unsigned NM    = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WP    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_w_order_ctrl_m3_if #(.NUM_MASTER(NM), .W_PTR(WP)) bus ();

  axi_w_order_ctrl_m3 #(.NUM_MASTER(NM), .DEPTH(DEPTH), .W_PTR(WP)) dut (
    .AXI_CLK (clk),
    .AXI_RST (rst),
    .bus     (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: pending writes in acceptance order; head is granted while active.
  typedef struct {
    logic [2:0] g;
    int         len;
  } ent_t;
  ent_t mq[$];
  bit   m_valid     = 1'b0;
  bit   m_active    = 1'b0;
  bit   m_err_wlast = 1'b0;
  bit   m_err_ovf   = 1'b0;
  int   m_beats     = 0;

  int ord_g[4] = '{4, 1, 1, 2};
  bit ord_l[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  function automatic void check(string name, int act, int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int exp_grant();
    if (m_active) return int'(mq[0].g);
    return 0;
  endfunction

  function automatic void model_step();
    bit   aw_hs, ok, beat, wend;
    int   n_before;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_active    = 1'b0;
      m_beats     = 0;
      m_err_wlast = 1'b0;
      m_err_ovf   = 1'b0;
      m_valid     = 1'b1;
      return;
    end
    if (!m_valid) return;
    n_before = mq.size();
    aw_hs    = bus.S_AWVALID && bus.S_AWREADY;
    ok       = $onehot(bus.AWGRANT) && (n_before < DEPTH);
    if (aw_hs && !ok) m_err_ovf = 1'b1;
    beat = m_active && bus.S_WVALID && bus.S_WREADY;
    wend = beat && bus.S_WLAST;
    if (beat) begin
      if (bus.S_WLAST != (m_beats == mq[0].len)) m_err_wlast = 1'b1;
      if (m_beats < 255) m_beats++;
    end
    if (wend) void'(mq.pop_front());
    if (aw_hs && ok) begin
      e.g   = bus.AWGRANT;
      e.len = int'(bus.S_AWLEN);
      mq.push_back(e);
    end
    if (!m_active) begin
      if (n_before != 0) begin
        m_active = 1'b1;
        m_beats  = 0;
      end
    end else if (wend) begin
      m_active = (mq.size() != 0);
      m_beats  = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("grant",     int'(bus.w_order_grant), exp_grant());
      check("occupancy", int'(bus.occupancy),     mq.size());
      check("aw_stall",  int'(bus.aw_stall),      int'(mq.size() == DEPTH));
      check("err_wlast", int'(bus.err_wlast),     int'(m_err_wlast));
      check("err_ovf",   int'(bus.err_ovf),       int'(m_err_ovf));
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.AWGRANT   = '0;
    bus.S_AWVALID = 1'b0;
    bus.S_AWREADY = 1'b0;
    bus.S_AWLEN   = '0;
    bus.S_WVALID  = 1'b0;
    bus.S_WREADY  = 1'b0;
    bus.S_WLAST   = 1'b0;
  endtask

  task automatic aw(input logic [2:0] g, input int len);
    bus.S_AWVALID = 1'b1;
    bus.S_AWREADY = 1'b1;
    bus.AWGRANT   = g;
    bus.S_AWLEN   = 8'(len);
    tick();
    bus.S_AWVALID = 1'b0;
    bus.S_AWREADY = 1'b0;
  endtask

  task automatic beat(input bit last);
    bus.S_WVALID = 1'b1;
    bus.S_WREADY = 1'b1;
    bus.S_WLAST  = last;
    tick();
    bus.S_WVALID = 1'b0;
    bus.S_WREADY = 1'b0;
    bus.S_WLAST  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    bit lastok;
    rst = 1'b1;
    clear_in();
    repeat (2) tick();
    rst = 1'b0;
    check("rst_occ",   int'(bus.occupancy), 0);
    check("rst_grant", int'(bus.w_order_grant), 0);
    check("rst_stall", int'(bus.aw_stall), 0);
    check("rst_errs",  int'({bus.err_wlast, bus.err_ovf}), 0);

    // Single write: M1, AWLEN=3
    aw(3'b010, 3);
    check("single_n1_grant", int'(bus.w_order_grant), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("single_beat_grant", int'(bus.w_order_grant), 2);
      beat(i == 3);
    end
    check("single_end_grant", int'(bus.w_order_grant), 0);
    check("single_err_wlast", int'(bus.err_wlast), 0);

    // Ordering: M2, M0, M1 with back-to-back bursts
    aw(3'b100, 0);
    aw(3'b001, 1);
    aw(3'b010, 0);
    check("order_peak_occ", int'(bus.occupancy), 3);
    for (int i = 0; i < 4; i++) begin
      check("order_grant", int'(bus.w_order_grant), ord_g[i]);
      beat(ord_l[i]);
    end
    check("order_end_grant", int'(bus.w_order_grant), 0);

    // Full FIFO and overflow
    repeat (4) aw(3'b001, 0);
    check("full_occ",   int'(bus.occupancy), 4);
    check("full_stall", int'(bus.aw_stall), 1);
    aw(3'b010, 0);
    check("ovf_err", int'(bus.err_ovf), 1);
    check("ovf_occ", int'(bus.occupancy), 4);
    beat(1'b1);
    check("unstall", int'(bus.aw_stall), 0);
    repeat (3) beat(1'b1);
    check("drain_occ", int'(bus.occupancy), 0);
    do_reset(1);
    check("ovf_cleared", int'(bus.err_ovf), 0);

    // Early WLAST
    aw(3'b001, 2);
    tick();
    beat(1'b0);
    beat(1'b1);
    check("early_last_err", int'(bus.err_wlast), 1);
    check("early_last_pop", int'(bus.occupancy), 0);
    do_reset(1);

    // Missing WLAST on single-beat burst
    aw(3'b001, 0);
    tick();
    beat(1'b0);
    check("missing_last_err", int'(bus.err_wlast), 1);
    check("missing_last_occ", int'(bus.occupancy), 1);
    beat(1'b1);
    check("missing_last_pop", int'(bus.occupancy), 0);
    do_reset(1);

    // Reset mid-burst
    aw(3'b010, 3);
    aw(3'b100, 3);
    check("midrst_occ", int'(bus.occupancy), 2);
    check("midrst_grant", int'(bus.w_order_grant), 2);
    beat(1'b0);
    rst = 1'b1;
    beat(1'b0);
    rst = 1'b0;
    check("midrst_occ0", int'(bus.occupancy), 0);
    check("midrst_grant0", int'(bus.w_order_grant), 0);
    aw(3'b001, 0);
    tick();
    check("post_rst_grant", int'(bus.w_order_grant), 1);
    beat(1'b1);
    check("post_rst_occ", int'(bus.occupancy), 0);
    check("post_rst_err", int'(bus.err_wlast), 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.S_AWVALID = ($urandom_range(0, 99) < 40);
      bus.S_AWREADY = (mq.size() < DEPTH) || ($urandom_range(0, 49) == 0);
      bus.AWGRANT   = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(0, 7))
                                                   : 3'(1 << $urandom_range(0, 2));
      bus.S_AWLEN   = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(4, 12))
                                                   : 8'($urandom_range(0, 3));
      bus.S_WVALID  = ($urandom_range(0, 99) < 60);
      bus.S_WREADY  = ($urandom_range(0, 99) < 70);
      lastok = 1'b0;
      if (m_active) lastok = (m_beats >= mq[0].len);
      bus.S_WLAST   = ($urandom_range(0, 79) == 0) ? !lastok : lastok;
      tick();
    end
    rst = 1'b0;
    clear_in();
    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
